// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: BTB entry layout,
// 2-bit direction counter, predictor FSM states and counter helpers.
package branch_predictor_pkg;

    localparam int unsigned PC_WIDTH        = 32;
    // Wide enough for the smallest index; unused upper bits stay zero.
    localparam int unsigned TAG_FIELD_WIDTH = 30;

    typedef logic [PC_WIDTH-1:0]        PC;
    typedef logic [TAG_FIELD_WIDTH-1:0] BtbTag;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } BranchCounter;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } BpState;

    typedef struct packed {
        logic         valid;
        BtbTag        tag;
        PC            target;
        BranchCounter ctr;
    } BtbEntry;

    localparam BtbEntry INIT_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};

    // pc[1:0] never contributes; the index bits are shifted out.
    function automatic BtbTag tagOf(input PC pc, input int unsigned indexWidth);
        return BtbTag'(pc[PC_WIDTH-1:2] >> indexWidth);
    endfunction

    function automatic BranchCounter ctrInc(input BranchCounter c);
        return (c == STRONG_T) ? STRONG_T : BranchCounter'(c + 2'd1);
    endfunction

    function automatic BranchCounter ctrDec(input BranchCounter c);
        return (c == STRONG_NT) ? STRONG_NT : BranchCounter'(c - 2'd1);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute <-> predictor signal bundle. master = fetch + execute side,
// slave = the predictor itself.
interface branch_predictor_if;
    import branch_predictor_pkg::*;

    PC    fetchPc;
    logic predTaken;
    PC    predTarget;
    logic updValid;
    PC    updPc;
    logic updTaken;
    PC    updTarget;
    logic ready;

    modport master (
        output fetchPc, updValid, updPc, updTaken, updTarget,
        input  predTaken, predTarget, ready
    );

    modport slave (
        input  fetchPc, updValid, updPc, updTaken, updTarget,
        output predTaken, predTarget, ready
    );

endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB storage: combinational reads, one synchronous write port.
// No reset; the predictor's init sweep clears every entry.
module branch_target_buffer
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic                   clk,
    input  logic [INDEX_WIDTH-1:0] lookupIdx,
    output BtbEntry                lookupEntry,
    input  logic [INDEX_WIDTH-1:0] trainIdx,
    output BtbEntry                trainEntry,
    input  logic                   wrEn,
    input  logic [INDEX_WIDTH-1:0] wrIdx,
    input  BtbEntry                wrEntry
);

    localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;

    BtbEntry entries [ENTRIES];

    // The training read feeds read-modify-write of the counter; it never
    // bypasses into the lookup port, so same-cycle lookups see old state.
    assign lookupEntry = entries[lookupIdx];
    assign trainEntry  = entries[trainIdx];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            entries[wrIdx] <= wrEntry;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit counters,
// cleared by an init sweep after reset and trained by execute.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_if.slave   bp
);

    BpState                 state;
    BpState                 nextState;
    logic [INDEX_WIDTH-1:0] sweepIdx;
    logic [INDEX_WIDTH-1:0] nextSweepIdx;

    logic [INDEX_WIDTH-1:0] lookupIdx;
    logic [INDEX_WIDTH-1:0] trainIdx;
    BtbEntry                lookupEntry;
    BtbEntry                trainEntry;

    logic                   wrEn;
    logic [INDEX_WIDTH-1:0] wrIdx;
    BtbEntry                wrEntry;

    logic                   isReady;
    logic                   lookupHit;
    logic                   trainHit;
    logic                   predTakenInt;

    assign lookupIdx = bp.fetchPc[INDEX_WIDTH+1:2];
    assign trainIdx  = bp.updPc[INDEX_WIDTH+1:2];

    branch_target_buffer #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) btb (
        .clk         (clk),
        .lookupIdx   (lookupIdx),
        .lookupEntry (lookupEntry),
        .trainIdx    (trainIdx),
        .trainEntry  (trainEntry),
        .wrEn        (wrEn),
        .wrIdx       (wrIdx),
        .wrEntry     (wrEntry)
    );

    assign lookupHit = lookupEntry.valid && (lookupEntry.tag == tagOf(bp.fetchPc, INDEX_WIDTH));
    assign trainHit  = trainEntry.valid  && (trainEntry.tag  == tagOf(bp.updPc,   INDEX_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BP_INIT;
            sweepIdx <= '0;
        end else begin
            state    <= nextState;
            sweepIdx <= nextSweepIdx;
        end
    end

    // Single write port: the sweep owns it in INIT, training owns it in RUN.
    always_comb begin
        nextState    = state;
        nextSweepIdx = sweepIdx;
        wrEn         = 1'b0;
        wrIdx        = trainIdx;
        wrEntry      = trainEntry;
        case (state)
            BP_INIT: begin
                wrEn         = 1'b1;
                wrIdx        = sweepIdx;
                wrEntry      = INIT_ENTRY;
                nextSweepIdx = sweepIdx + 1'b1;
                if (sweepIdx == '1) begin
                    nextState = BP_RUN;
                end
            end
            BP_RUN: begin
                if (bp.updValid) begin
                    if (trainHit) begin
                        wrEn = 1'b1;
                        if (bp.updTaken) begin
                            wrEntry.ctr    = ctrInc(trainEntry.ctr);
                            wrEntry.target = bp.updTarget;
                        end else begin
                            wrEntry.ctr    = ctrDec(trainEntry.ctr);
                        end
                    end else if (bp.updTaken) begin
                        wrEn    = 1'b1;
                        wrEntry = '{valid:  1'b1,
                                    tag:    tagOf(bp.updPc, INDEX_WIDTH),
                                    target: bp.updTarget,
                                    ctr:    WEAK_T};
                    end
                end
            end
        endcase
    end

    assign isReady      = (state == BP_RUN);
    assign predTakenInt = isReady && lookupHit && lookupEntry.ctr[1];

    assign bp.ready      = isReady;
    assign bp.predTaken  = predTakenInt;
    assign bp.predTarget = predTakenInt ? lookupEntry.target : bp.fetchPc + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a per-cycle reference model and
// hand-computed checkpoints.
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_predictor_if bpIf ();

    branch_predictor #(
        .INDEX_WIDTH (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bpIf)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: 64 entries, tags are pc>>8, counters are 0..3.
    bit          armed = 1'b0;
    int          initLeft = 0;
    bit          mValid  [64];
    int unsigned mTag    [64];
    logic [31:0] mTarget [64];
    int          mCtr    [64];

    int unsigned uIdx;
    int unsigned cIdx;
    bit          uHit;
    bit          eTaken;
    logic [31:0] eTarget;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            armed    = 1'b1;
            initLeft = 64;
        end else if (armed) begin
            if (initLeft > 0) begin
                mValid[64 - initLeft] = 1'b0;
                initLeft--;
            end else if (bpIf.updValid) begin
                uIdx = (bpIf.updPc >> 2) % 64;
                uHit = mValid[uIdx] && (mTag[uIdx] == (bpIf.updPc >> 8));
                if (uHit) begin
                    if (bpIf.updTaken) begin
                        mCtr[uIdx]    = (mCtr[uIdx] < 3) ? mCtr[uIdx] + 1 : 3;
                        mTarget[uIdx] = bpIf.updTarget;
                    end else begin
                        mCtr[uIdx]    = (mCtr[uIdx] > 0) ? mCtr[uIdx] - 1 : 0;
                    end
                end else if (bpIf.updTaken) begin
                    mValid[uIdx]  = 1'b1;
                    mTag[uIdx]    = bpIf.updPc >> 8;
                    mTarget[uIdx] = bpIf.updTarget;
                    mCtr[uIdx]    = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            cIdx    = (bpIf.fetchPc >> 2) % 64;
            eTaken  = (initLeft == 0) && mValid[cIdx] &&
                      (mTag[cIdx] == (bpIf.fetchPc >> 8)) && (mCtr[cIdx] >= 2);
            eTarget = eTaken ? mTarget[cIdx] : bpIf.fetchPc + 32'd4;
            check("model.ready",      bpIf.ready,      (initLeft == 0));
            check("model.predTaken",  bpIf.predTaken,  eTaken);
            check("model.predTarget", bpIf.predTarget, eTarget);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        bpIf.updValid  = 1'b1;
        bpIf.updPc     = pc;
        bpIf.updTaken  = taken;
        bpIf.updTarget = target;
        cyc();
        bpIf.updValid  = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic expTaken, input logic [31:0] expTarget);
        bpIf.fetchPc = pc;
        #2;
        check({name, ".predTaken"},  bpIf.predTaken,  expTaken);
        check({name, ".predTarget"}, bpIf.predTarget, expTarget);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bpIf.fetchPc   = 32'h100;
        bpIf.updValid  = 1'b0;
        bpIf.updPc     = '0;
        bpIf.updTaken  = 1'b0;
        bpIf.updTarget = '0;
        cyc();
        rst = 1'b0;

        for (int c = 0; c < 64; c++) begin
            #2;
            check("init.ready",      bpIf.ready,      1'b0);
            check("init.predTaken",  bpIf.predTaken,  1'b0);
            check("init.predTarget", bpIf.predTarget, 32'h104);
            cyc();
        end
        #2;
        check("init.readyAfter64", bpIf.ready, 1'b1);

        upd(32'h100, 1'b1, 32'h40);
        look("alloc.hit",      32'h100,      1'b1, 32'h40);
        look("alloc.lowBits",  32'h102,      1'b1, 32'h40);
        look("alloc.otherTag", 32'h200,      1'b0, 32'h204);
        look("seq.wrap",       32'hFFFFFFFC, 1'b0, 32'h0);

        upd(32'h100, 1'b0, 32'h0);
        look("hyst.weakNt", 32'h100, 1'b0, 32'h104);
        repeat (3) upd(32'h100, 1'b1, 32'h40);
        upd(32'h100, 1'b0, 32'h0);
        look("hyst.strongHold", 32'h100, 1'b1, 32'h40);
        repeat (4) upd(32'h100, 1'b0, 32'h0);
        look("hyst.floor", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h44);
        look("hyst.noWrap", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h44);
        look("hyst.recover", 32'h100, 1'b1, 32'h44);

        upd(32'h300, 1'b0, 32'h900);
        look("ntMiss.noAlloc", 32'h300, 1'b0, 32'h304);
        look("ntMiss.keep",    32'h100, 1'b1, 32'h44);

        bpIf.fetchPc   = 32'h104;
        bpIf.updValid  = 1'b1;
        bpIf.updPc     = 32'h104;
        bpIf.updTaken  = 1'b1;
        bpIf.updTarget = 32'h80;
        #2;
        check("same.before.predTaken",  bpIf.predTaken,  1'b0);
        check("same.before.predTarget", bpIf.predTarget, 32'h108);
        cyc();
        bpIf.updValid = 1'b0;
        #2;
        check("same.after.predTaken",  bpIf.predTaken,  1'b1);
        check("same.after.predTarget", bpIf.predTarget, 32'h80);
        cyc();

        upd(32'h100, 1'b1, 32'h40);
        look("midRst.pre", 32'h100, 1'b1, 32'h40);
        rst          = 1'b1;
        bpIf.fetchPc = 32'h100;
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 64; c++) begin
            bpIf.updValid  = (c % 8 == 3);
            bpIf.updPc     = (c % 16 == 3) ? 32'h100 : 32'h108;
            bpIf.updTaken  = 1'b1;
            bpIf.updTarget = 32'h40;
            #2;
            check("midRst.ready",      bpIf.ready,      1'b0);
            check("midRst.predTaken",  bpIf.predTaken,  1'b0);
            check("midRst.predTarget", bpIf.predTarget, 32'h104);
            cyc();
        end
        bpIf.updValid = 1'b0;
        #2;
        check("midRst.readyAfter64", bpIf.ready, 1'b1);
        look("midRst.cleared",     32'h100, 1'b0, 32'h104);
        look("midRst.clearedOld",  32'h104, 1'b0, 32'h108);
        look("midRst.droppedUpd",  32'h108, 1'b0, 32'h10C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
